// File: rtl/eflash_col_seq_driver.sv
// eflash_col_seq_driver: eFlash column driver with built-in phase sequencer and input buffer
// Drives DUMH/PRECB/DISC for ERASE, PROGRAM, READ, PARALLEL-MAC and row-by-row MAC without an
// external exec counter.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, mode_i         operation request (accepted when idle or in the DONE cycle)
//   row_addr_i, col_addr_i  addresses latched on accept
//   in_we_i/in_addr_i/in_data_i  input-buffer write port (ignored while busy)
//   busy_o, done_o, phase_o operation status (phase 0 IDLE, 1 PRE, 2 EVAL, 3 DIS)
//   DUMH_o, PRECB_o, DISC_o macro column drive (PRECB active-low)
// Optional: define EFLASH_COL_ABORT_EN to add abort_i, which cuts PRE/EVAL short into DIS
//   (or ERASE/PROGRAM straight into DONE).
module eflash_col_seq_driver #(
   parameter int NUM_DUMH = 256,
   parameter int NUM_BL   = 128,
   parameter int IN_W     = 2,
   parameter int ROW_W    = 7,
   parameter int COL_W    = 9,
   parameter int GRP      = 8,
   parameter int PRE_CYC  = 3,
   parameter int DIS_CYC  = 3,
   parameter int HOLD_CYC = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [2:0]                  mode_i,
   input  logic [ROW_W-1:0]            row_addr_i,
   input  logic [COL_W-1:0]            col_addr_i,
   input  logic                        in_we_i,
   input  logic [$clog2(NUM_DUMH)-1:0] in_addr_i,
   input  logic [IN_W-1:0]             in_data_i,
`ifdef EFLASH_COL_ABORT_EN
   input  logic                        abort_i,
`endif
   output logic                        busy_o,
   output logic                        done_o,
   output logic [1:0]                  phase_o,
   output logic [NUM_DUMH-1:0]         DUMH_o,
   output logic [NUM_BL-1:0]           PRECB_o,
   output logic [NUM_BL-1:0]           DISC_o
);
   localparam int GW   = $clog2(GRP);
   localparam int L    = (1 << IN_W) - 1;
   localparam int M1   = PRE_CYC > DIS_CYC ? PRE_CYC : DIS_CYC;
   localparam int M2   = HOLD_CYC > L ? HOLD_CYC : L;
   localparam int CW   = $clog2((M1 > M2 ? M1 : M2) + 1);
   localparam logic [2:0] M_ERASE = 3'b001, M_PROG = 3'b010, M_READ = 3'b011,
                          M_PAR = 3'b101, M_RBR = 3'b110;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_EVAL, S_DIS, S_DONE} state_t;

   state_t              state_q, ns;
   logic [CW-1:0]       cnt_q, nc;
   logic [IN_W-1:0]     k_q, nk;
   logic [2:0]          mode_q, m;
   logic [GW-1:0]       rg_q, rg;
   logic [COL_W-3:0]    cq_q, cq;
   logic [IN_W-1:0]     mem_q [NUM_DUMH];
   logic                accept, hold, mac, abort;
   logic [NUM_DUMH-1:0] grp, prog_dumh, par, rbr, d_dumh;
   logic [NUM_BL-1:0]   prog_bl, d_precb, d_disc;
   int                  pd_idx;
   logic                unused_bits;

`ifdef EFLASH_COL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign unused_bits = ^{row_addr_i[ROW_W-GW-1:0], col_addr_i[1:0]};

   // On the accepting edge the first phase pattern is built from the live request inputs.
   assign accept = start_i && (state_q == S_IDLE || state_q == S_DONE);
   assign m      = accept ? mode_i : mode_q;
   assign rg     = accept ? row_addr_i[ROW_W-1 -: GW] : rg_q;
   assign cq     = accept ? col_addr_i[COL_W-1:2] : cq_q;
   assign hold   = m == M_ERASE || m == M_PROG;
   assign mac    = m == M_READ || m == M_PAR || m == M_RBR;
   assign pd_idx = int'(rg) + GRP * int'(cq >> 2);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         mode_q  <= '0;
         rg_q    <= '0;
         cq_q    <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         phase_o <= 2'd0;
         DUMH_o  <= '0;
         PRECB_o <= '1;
         DISC_o  <= '0;
         for (int i = 0; i < NUM_DUMH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= ns;
         cnt_q   <= nc;
         k_q     <= nk;
         busy_o  <= ns == S_PRE || ns == S_EVAL || ns == S_DIS;
         done_o  <= ns == S_DONE;
         phase_o <= ns == S_PRE ? 2'd1 : ns == S_EVAL ? 2'd2 : ns == S_DIS ? 2'd3 : 2'd0;
         DUMH_o  <= d_dumh;
         PRECB_o <= d_precb;
         DISC_o  <= d_disc;
         if (accept) begin
            mode_q <= mode_i;
            rg_q   <= row_addr_i[ROW_W-1 -: GW];
            cq_q   <= col_addr_i[COL_W-1:2];
         end
         if (in_we_i && !busy_o && int'(in_addr_i) < NUM_DUMH) mem_q[in_addr_i] <= in_data_i;
      end
   end

   // cnt counts remaining cycles of the current phase; k is the EVAL step.
   always_comb begin
      ns = state_q;
      nc = cnt_q - 1'b1;
      nk = k_q;
      case (state_q)
         S_PRE: begin
            if (abort) begin
               ns = S_DIS;
               nc = CW'(DIS_CYC - 1);
            end else if (cnt_q == '0) begin
               ns = S_EVAL;
               nc = CW'(L - 1);
               nk = '0;
            end
         end
         S_EVAL: begin
            if (abort || cnt_q == '0) begin
               ns = hold ? S_DONE : S_DIS;
               nc = CW'(DIS_CYC - 1);
            end else nk = k_q + 1'b1;
         end
         S_DIS: ns = cnt_q == '0 ? S_DONE : S_DIS;
         default: begin
            ns = accept ? (hold ? S_EVAL : mac ? S_PRE : S_DONE) : S_IDLE;
            nc = hold ? CW'(HOLD_CYC - 1) : CW'(PRE_CYC - 1);
            nk = '0;
         end
      endcase
   end

   // Output patterns for the state being entered.
   always_comb begin
      for (int i = 0; i < NUM_DUMH; i++) begin
         grp[i]       = (i % GRP) == int'(rg);
         prog_dumh[i] = i == pd_idx;
         par[i]       = mem_q[i] > nk;
         rbr[i]       = grp[i] && mem_q[i / GRP] > nk;
      end
      for (int i = 0; i < NUM_BL; i++) prog_bl[i] = i == int'(cq);
      d_dumh  = ns == S_PRE ? (m == M_PAR ? '1 : grp)
              : ns == S_EVAL ? (m == M_PROG ? prog_dumh : m == M_READ ? (nk == '0 ? grp : '0)
                               : m == M_PAR ? par : m == M_RBR ? rbr : '0)
              : '0;
      d_precb = ns == S_PRE ? '0 : (ns == S_EVAL && m == M_PROG) ? prog_bl : '1;
      d_disc  = (ns == S_PRE || ns == S_EVAL) ? (m == M_PROG ? prog_bl : '1) : '0;
   end
endmodule

// File: tb/tb_eflash_col_seq_driver.sv
// tb_eflash_col_seq_driver: table-driven, hand-written and randomized checks of eflash_col_seq_driver
module tb_eflash_col_seq_driver;
   localparam int ND = 256, NB = 128, G = 8, PC = 3, DC = 3, HC = 4, L = 3;
   localparam logic [2:0] ERASE = 3'b001, PROG = 3'b010, READ = 3'b011, PAR = 3'b101, RBR = 3'b110;

   logic          clk_i = 1'b0;
   logic          rst_i, start_i, in_we_i;
   logic [2:0]    mode_i;
   logic [6:0]    row_addr_i;
   logic [8:0]    col_addr_i;
   logic [7:0]    in_addr_i;
   logic [1:0]    in_data_i;
   logic          busy_o, done_o;
   logic [1:0]    phase_o;
   logic [ND-1:0] DUMH_o;
   logic [NB-1:0] PRECB_o, DISC_o;
`ifdef EFLASH_COL_ABORT_EN
   logic          abort_i = 1'b0;
`endif

   int checks = 0, errors = 0;
   int mbuf [ND];
   logic [2:0][31:0] cap_d, cap_c;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic [1:0]    ph;
      logic [ND-1:0] dumh;
      logic [NB-1:0] precb;
      logic [NB-1:0] disc;
   } out_t;

   typedef struct packed {
      logic [2:0]       md;
      logic [6:0]       row;
      logic [8:0]       col;
      logic [3:0][1:0]  b;
      logic [3:0]       t;
      logic [2:0][31:0] d;
      logic [2:0][31:0] c;
   } vec_t;

   vec_t tbl [8];

   eflash_col_seq_driver dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
      .row_addr_i(row_addr_i), .col_addr_i(col_addr_i), .in_we_i(in_we_i),
      .in_addr_i(in_addr_i), .in_data_i(in_data_i),
`ifdef EFLASH_COL_ABORT_EN
      .abort_i(abort_i),
`endif
      .busy_o(busy_o), .done_o(done_o), .phase_o(phase_o),
      .DUMH_o(DUMH_o), .PRECB_o(PRECB_o), .DISC_o(DISC_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [ND-1:0] got, input logic [ND-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_busy"}, busy_o, 0);
      chk({nm, "_done"}, done_o, 0);
      chk({nm, "_phase"}, phase_o, 0);
      chk({nm, "_dumh"}, DUMH_o, '0);
      chk({nm, "_precb"}, PRECB_o, {NB{1'b1}});
      chk({nm, "_disc"}, DISC_o, '0);
   endtask

   function automatic int op_len(input logic [2:0] md);
      return (md == ERASE || md == PROG) ? HC : (md == READ || md == PAR || md == RBR) ? PC + L + DC : 0;
   endfunction

   // Expected outputs n cycles after the accepting edge, straight from the phase rules.
   function automatic out_t model(input logic [2:0] md, input int rg, input int col, input int n);
      out_t o;
      int t = op_len(md);
      int k;
      o.busy = n < t; o.done = n == t; o.ph = 0;
      o.dumh = '0; o.precb = '1; o.disc = '0;
      if (n >= t) return o;
      if (md == ERASE || md == PROG) begin
         o.ph = 2; o.disc = '1;
         if (md == PROG) begin
            o.precb = '0; o.disc = '0;
            if (col / 4 < NB) begin o.precb[col / 4] = 1'b1; o.disc[col / 4] = 1'b1; end
            if (rg + G * (col / 16) < ND) o.dumh[rg + G * (col / 16)] = 1'b1;
         end
      end else if (n < PC) begin
         o.ph = 1; o.precb = '0; o.disc = '1;
         for (int i = 0; i < ND; i++) o.dumh[i] = md == PAR || i % G == rg;
      end else if (n < PC + L) begin
         k = n - PC; o.ph = 2; o.disc = '1;
         for (int i = 0; i < ND; i++)
            o.dumh[i] = md == READ ? (k == 0 && i % G == rg) : md == PAR ? mbuf[i] > k
                      : (i % G == rg && mbuf[i / G] > k);
      end else o.ph = 3;
      return o;
   endfunction

   task automatic wr(input int a, input int d);
      in_we_i = 1'b1; in_addr_i = 8'(a); in_data_i = 2'(d);
      tick;
      in_we_i = 1'b0;
      mbuf[a] = d;
   endtask

   // Starts an op in the current (idle or DONE) cycle and follows it to done_o, scrambling inputs while busy.
   task automatic run_op(input logic [2:0] md, input logic [6:0] row, input logic [8:0] col, input int exp_t);
      int rg = int'(row[6:4]);
      int t = op_len(md);
      int n, k;
      out_t e;
      start_i = 1'b1; mode_i = md; row_addr_i = row; col_addr_i = col; in_we_i = 1'b0;
      tick;
      for (n = 0; n <= 40; n++) begin
         e = model(md, rg, int'(col), n);
         chk($sformatf("busy m%0d n%0d", md, n), busy_o, e.busy);
         chk($sformatf("done m%0d n%0d", md, n), done_o, e.done);
         chk($sformatf("phase m%0d n%0d", md, n), phase_o, e.ph);
         chk($sformatf("dumh m%0d n%0d", md, n), DUMH_o, e.dumh);
         chk($sformatf("precb m%0d n%0d", md, n), PRECB_o, e.precb);
         chk($sformatf("disc m%0d n%0d", md, n), DISC_o, e.disc);
         k = (md == ERASE || md == PROG) ? n : n - PC;
         if (e.ph == 2 && k < 3) begin cap_d[k] = DUMH_o[31:0]; cap_c[k] = DISC_o[31:0]; end
         if (n < t) begin
            start_i = 1'($urandom); mode_i = 3'($urandom); row_addr_i = 7'($urandom);
            col_addr_i = 9'($urandom); in_we_i = 1'($urandom); in_addr_i = 8'($urandom_range(0, 39));
            in_data_i = 2'($urandom);
         end else begin
            start_i = 1'b0; in_we_i = 1'b0;
         end
         if (done_o) break;
         tick;
      end
      start_i = 1'b0; in_we_i = 1'b0;
      chk($sformatf("done_idx m%0d", md), n, exp_t);
   endtask

   initial begin
      tbl[0] = '{md: PAR,   row: 7'h00, col: 9'h000, b: {2'd3, 2'd2, 2'd1, 2'd0}, t: 4'd9,
                 d: {32'h8, 32'hC, 32'hE}, c: {3{32'hFFFF_FFFF}}};
      tbl[1] = '{md: RBR,   row: 7'h35, col: 9'h000, b: {2'd0, 2'd0, 2'd1, 2'd3}, t: 4'd9,
                 d: {32'h8, 32'h8, 32'h0808}, c: {3{32'hFFFF_FFFF}}};
      tbl[2] = '{md: PROG,  row: 7'h20, col: 9'h025, b: '0, t: 4'd4,
                 d: {3{32'h0004_0000}}, c: {3{32'h200}}};
      tbl[3] = '{md: READ,  row: 7'h35, col: 9'h000, b: '0, t: 4'd9,
                 d: {32'h0, 32'h0, 32'h0808_0808}, c: {3{32'hFFFF_FFFF}}};
      tbl[4] = '{md: ERASE, row: 7'h7F, col: 9'h1FF, b: '0, t: 4'd4,
                 d: '0, c: {3{32'hFFFF_FFFF}}};
      tbl[5] = '{md: 3'b111, row: 7'h11, col: 9'h011, b: '0, t: 4'd0, d: '0, c: '0};
      tbl[6] = '{md: PROG,  row: 7'h7F, col: 9'h1FF, b: '0, t: 4'd4, d: '0, c: '0};
      tbl[7] = '{md: 3'b000, row: 7'h00, col: 9'h000, b: '0, t: 4'd0, d: '0, c: '0};

      foreach (mbuf[i]) mbuf[i] = 0;
      rst_i = 1'b1; start_i = 1'b0; in_we_i = 1'b0; mode_i = '0;
      row_addr_i = '0; col_addr_i = '0; in_addr_i = '0; in_data_i = '0;
      repeat (2) tick;
      chk_idle("reset");
      rst_i = 1'b0;
      tick;

      for (int v = 0; v < 8; v++) begin
         for (int j = 0; j < 4; j++) wr(j, int'(tbl[v].b[j]));
         cap_d = '0; cap_c = '0;
         run_op(tbl[v].md, tbl[v].row, tbl[v].col, int'(tbl[v].t));
         if (tbl[v].t != 0)
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("tbl%0d eval_dumh k%0d", v, k), cap_d[k], tbl[v].d[k]);
               chk($sformatf("tbl%0d eval_disc k%0d", v, k), cap_c[k], tbl[v].c[k]);
            end
      end

      // back-to-back: start in the DONE cycle of the previous op
      run_op(READ, 7'h00, 9'h000, 9);
      run_op(PROG, 7'h10, 9'h044, 4);
      tick;

      // reset held two cycles in the middle of a PARALLEL op
      start_i = 1'b1; mode_i = PAR; row_addr_i = '0; col_addr_i = '0;
      tick;
      start_i = 1'b0;
      repeat (3) tick;
      rst_i = 1'b1;
      tick;
      chk_idle("rst_mid1");
      tick;
      chk_idle("rst_mid2");
      rst_i = 1'b0;
      foreach (mbuf[i]) mbuf[i] = 0;
      tick;
      chk_idle("rst_after");

      for (int r = 0; r < 60; r++) begin
         logic [2:0] md;
         repeat ($urandom_range(0, 3)) wr($urandom_range(0, 39), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) tick;
         md = 3'($urandom);
         run_op(md, 7'($urandom), 9'($urandom), op_len(md));
      end
      tick;

`ifdef EFLASH_COL_ABORT_EN
      start_i = 1'b1; mode_i = PAR;
      tick;
      start_i = 1'b0;
      repeat (4) tick;
      chk("ab_eval_phase", phase_o, 2);
      abort_i = 1'b1;
      tick;
      abort_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ab_dis_phase %0d", i), phase_o, 3);
         chk($sformatf("ab_dis_disc %0d", i), DISC_o, '0);
         tick;
      end
      chk("ab_done", done_o, 1);
      tick;
      start_i = 1'b1; mode_i = ERASE;
      tick;
      start_i = 1'b0;
      abort_i = 1'b1;
      tick;
      abort_i = 1'b0;
      chk("ab_erase_done", done_o, 1);
      tick;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
